mb_alu_seq: RTL and testbench

MB_ALU_SEQ -- requirements
Module: mb_alu_seq

---
 rtl/mb_alu_seq.sv | 136 +++++++++++++
 tb/tb_mb_alu_seq.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mb_alu_seq.sv
// Byte-serial 32-bit ADD/SUB/CMP/AND sequencer that drives an external 8-bit ALU.
// Carries between bytes are applied as a separate INC/DEC pass (FIX), because the ALU has no carry-in.
module mb_alu_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [1:0]  len,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        done,
    output logic [31:0] result,
    output logic        c_out,
    output logic        z_out,
    output logic        s_out,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    input  logic [7:0]  alu_result,
    input  logic        alu_c
);
    typedef enum logic [1:0] {S_IDLE, S_BYTE, S_FIX, S_DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_CMP = 2'b10, OP_AND = 2'b11;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0100,
                           ALU_INC = 4'b1000, ALU_DEC = 4'b1001;

    state_t      state_q;
    logic [1:0]  op_q, len_q, i_q;
    logic [31:0] a_q, b_q, acc_q;
    logic [7:0]  tmp_q;
    logic        pc_q, cy_q, zacc_q;
    logic        ready_q, done_q, c_q, z_q, s_q;

    logic [7:0]  a_byte, b_byte, res_byte;
    logic        need_fix, complete, bcarry, zacc_d, last;

    assign a_byte = a_q[{i_q, 3'b000} +: 8];
    assign b_byte = b_q[{i_q, 3'b000} +: 8];

    always_comb begin
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_op = ALU_ADD;
        case (state_q)
            S_BYTE: begin
                alu_a  = a_byte;
                alu_b  = b_byte;
                alu_op = (op_q == OP_AND) ? ALU_AND : (op_q == OP_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_FIX: begin
                alu_b  = tmp_q;
                alu_op = (op_q == OP_ADD) ? ALU_INC : ALU_DEC;
            end
            default: ;
        endcase
    end

    // A pending carry/borrow from the previous byte forces a FIX pass on this byte.
    assign need_fix = (state_q == S_BYTE) && (op_q != OP_AND) && cy_q;
    assign complete = ((state_q == S_BYTE) && !need_fix) || (state_q == S_FIX);
    assign bcarry   = (state_q == S_FIX) ? (pc_q | alu_c) : ((op_q != OP_AND) && alu_c);
    assign zacc_d   = zacc_q & (alu_result == 8'h00);
    assign last     = (i_q == len_q);
    assign res_byte = (op_q == OP_CMP) ? a_byte : alu_result;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            len_q   <= 2'b00;
            i_q     <= 2'b00;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            acc_q   <= 32'h0;
            tmp_q   <= 8'h00;
            pc_q    <= 1'b0;
            cy_q    <= 1'b0;
            zacc_q  <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    op_q    <= op;
                    len_q   <= len;
                    a_q     <= a;
                    b_q     <= b;
                    i_q     <= 2'b00;
                    cy_q    <= 1'b0;
                    zacc_q  <= 1'b1;
                    acc_q   <= 32'h0;
                    ready_q <= 1'b0;
                    state_q <= S_BYTE;
                end
                S_BYTE: begin
                    tmp_q <= alu_result;
                    pc_q  <= alu_c;
                    if (need_fix) state_q <= S_FIX;
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: ;
            endcase
            if (complete) begin
                cy_q   <= bcarry;
                zacc_q <= zacc_d;
                acc_q[{i_q, 3'b000} +: 8] <= res_byte;
                if (last) begin
                    done_q  <= 1'b1;
                    c_q     <= bcarry;
                    z_q     <= zacc_d;
                    s_q     <= alu_result[7];
                    state_q <= S_DONE;
                end else begin
                    i_q     <= i_q + 2'd1;
                    state_q <= S_BYTE;
                end
            end
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = acc_q;
    assign c_out  = c_q;
    assign z_out  = z_q;
    assign s_out  = s_q;
endmodule

// File: tb/tb_mb_alu_seq.sv
// Directed bench for mb_alu_seq with a behavioural 8-bit ALU in the loop.
module tb_mb_alu_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op, len;
    logic [31:0] a, b;
    logic        ready, done, c_out, z_out, s_out;
    logic [31:0] result;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mb_alu_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .len(len), .a(a), .b(b),
        .ready(ready), .done(done), .result(result), .c_out(c_out), .z_out(z_out), .s_out(s_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_c(alu_c)
    );

    // Shared ALU model: carry on ADD/INC, borrow on SUB/DEC.
    logic [8:0] t9;
    always_comb begin
        t9 = 9'h000;
        case (alu_op)
            4'b0000: t9 = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: t9 = {1'b0, alu_a} - {1'b0, alu_b};
            4'b0100: t9 = {1'b0, alu_a & alu_b};
            4'b1000: t9 = {1'b0, alu_a} + {1'b0, alu_b} + 9'd1;
            4'b1001: t9 = {1'b0, alu_b} - {1'b0, alu_a} - 9'd1;
            default: t9 = 9'h000;
        endcase
        alu_result = t9[7:0];
        alu_c      = t9[8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [1:0] l,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eres, input logic [2:0] eczs, input int elat,
                       input bit glitch);
        int n;
        @(negedge clk);
        chk({tag, ".rdy"}, {31'b0, ready}, 32'd1);
        chk({tag, ".idle_done"}, {31'b0, done}, 32'd0);
        start = 1'b1; op = o; len = l; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; a = 32'hDEADBEEF; b = 32'hCAFEF00D; op = 2'b11;
        n = 0;
        while (n < 20 && !done) begin
            @(negedge clk);
            n++;
            if (glitch && n == 1) begin
                chk({tag, ".busy"}, {31'b0, ready}, 32'd0);
                start = 1'b1; op = 2'b00; len = 2'b00; a = 32'h5; b = 32'h6;
            end else if (glitch && n == 2) begin
                start = 1'b0;
            end
        end
        chk({tag, ".lat"}, n, elat);
        chk({tag, ".res"}, result, eres);
        chk({tag, ".czs"}, {29'b0, c_out, z_out, s_out}, {29'b0, eczs});
        chk({tag, ".alu_done"}, {16'b0, alu_a, alu_b}, 32'd0);
        chk({tag, ".aluop_done"}, {28'b0, alu_op}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'b00; len = 2'b00; a = 32'h0; b = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst.rdy", {31'b0, ready}, 32'd1);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.res", result, 32'd0);
        chk("rst.czs", {29'b0, c_out, z_out, s_out}, 32'd0);
        chk("rst.alu", {12'b0, alu_a, alu_b, alu_op}, 32'd0);
        reset_n = 1'b1;

        //       tag         op     len    a             b             result        czs     lat glitch
        run("add_fix",   2'b00, 2'b01, 32'h000000FF, 32'h00000001, 32'h00000100, 3'b000, 4, 1'b0);
        run("sub_b0",    2'b01, 2'b00, 32'h00000000, 32'h00000001, 32'h000000FF, 3'b101, 2, 1'b0);
        run("add_wrap",  2'b00, 2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b110, 8, 1'b0);
        run("cmp_eq",    2'b10, 2'b01, 32'h00001234, 32'h00001234, 32'h00001234, 3'b010, 3, 1'b0);
        run("and_z",     2'b11, 2'b00, 32'h000000F0, 32'h0000000F, 32'h00000000, 3'b010, 2, 1'b0);
        run("add_mask",  2'b00, 2'b00, 32'hAABBCC80, 32'h11223380, 32'h00000000, 3'b110, 2, 1'b0);
        run("cmp_lt",    2'b10, 2'b01, 32'h00001000, 32'h00001001, 32'h00001000, 3'b101, 4, 1'b0);
        run("sub_glitch",2'b01, 2'b11, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 3'b101, 8, 1'b1);

        // Reset asserted while the sequencer is in a FIX cycle.
        @(negedge clk);
        start = 1'b1; op = 2'b00; len = 2'b01; a = 32'h000000FF; b = 32'h000000FF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("fix.op", {28'b0, alu_op}, 32'h8);
        chk("fix.res", result, 32'h000000FE);
        reset_n = 1'b0;
        #1;
        chk("mid.rdy", {31'b0, ready}, 32'd1);
        chk("mid.done", {31'b0, done}, 32'd0);
        chk("mid.res", result, 32'd0);
        chk("mid.czs", {29'b0, c_out, z_out, s_out}, 32'd0);
        chk("mid.alu", {12'b0, alu_a, alu_b, alu_op}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run("post_rst",  2'b00, 2'b00, 32'h00000001, 32'h00000002, 32'h00000003, 3'b000, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
